// File: rtl/fbcpu_mem_checker.sv
// End-of-run memory checker: lets the CPU run for RUN_CYCLES, then holds it and compares NUM_CHECKS RAM words.
// Optional macro FBCHK_STOP_ON_FAIL_EN ends the check sequence at the first mismatch.
module fbcpu_mem_checker #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10,
    parameter int NUM_CHECKS    = 4,
    parameter int RUN_CYCLES    = 10000,
    parameter int READ_LATENCY  = 1,
    localparam int IDX_W        = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_start,
    input  logic [NUM_CHECKS*ADDRESS_WIDTH-1:0] i_exp_addr,
    input  logic [NUM_CHECKS*DATA_WIDTH-1:0]    i_exp_data,
    input  logic [DATA_WIDTH-1:0]              i_ram_data,
    output logic                               o_cpu_hold,
    output logic [ADDRESS_WIDTH-1:0]           o_addr,
    output logic                               o_busy,
    output logic                               o_done,
    output logic                               o_pass,
    output logic [IDX_W-1:0]                   o_fail_idx,
    output logic [DATA_WIDTH-1:0]              o_fail_data,
    output logic [IDX_W:0]                     o_err_count
);

    localparam int RUN_W  = (RUN_CYCLES > 0) ? $clog2(RUN_CYCLES + 1) : 1;
    localparam int WAIT_W = $clog2(READ_LATENCY + 1);
    localparam int SLOTS  = 1 << IDX_W;

    localparam logic [RUN_W-1:0]  RUN_INIT  = RUN_W'(RUN_CYCLES);
    localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(READ_LATENCY);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CHECKS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W:0]    ERR_MAX   = (IDX_W + 1)'(NUM_CHECKS);
    localparam logic [IDX_W:0]    ERR_ONE   = (IDX_W + 1)'(1);

`ifdef FBCHK_STOP_ON_FAIL_EN
    localparam logic STOP_ON_FAIL = 1'b1;
`else
    localparam logic STOP_ON_FAIL = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, RUN, ISSUE, WAIT, COMPARE, DONE} stateT;

    stateT                    state;
    stateT                    stateNext;
    logic [RUN_W-1:0]         runCnt;
    logic [WAIT_W-1:0]        waitCnt;
    logic [IDX_W-1:0]         idx;
    logic [ADDRESS_WIDTH-1:0] entryAddr [SLOTS];
    logic [DATA_WIDTH-1:0]    entryData [SLOTS];
    logic                     mismatch;

    // Unpack the table into a power-of-two array so idx indexes it at its natural width.
    for (genvar k = 0; k < SLOTS; k++) begin : gEntry
        if (k < NUM_CHECKS) begin : gUsed
            assign entryAddr[k] = i_exp_addr[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            assign entryData[k] = i_exp_data[k*DATA_WIDTH +: DATA_WIDTH];
        end else begin : gPad
            assign entryAddr[k] = '0;
            assign entryData[k] = '0;
        end
    end

    assign mismatch = (i_ram_data != entryData[idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: if (i_start) stateNext = RUN;
            RUN:        if (runCnt == '0) stateNext = ISSUE;
            ISSUE:      stateNext = WAIT;
            WAIT:       if (waitCnt == WAIT_ONE) stateNext = COMPARE;
            COMPARE: begin
                if (idx == LAST_IDX || (STOP_ON_FAIL && mismatch)) begin
                    stateNext = DONE;
                end else begin
                    stateNext = ISSUE;
                end
            end
            default:    stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_cpu_hold  <= 1'b1;
            o_addr      <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_fail_idx  <= '0;
            o_fail_data <= '0;
            o_err_count <= '0;
            runCnt      <= '0;
            waitCnt     <= '0;
            idx         <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        o_done      <= 1'b0;
                        o_pass      <= 1'b0;
                        o_fail_idx  <= '0;
                        o_fail_data <= '0;
                        o_err_count <= '0;
                        idx         <= '0;
                        runCnt      <= RUN_INIT;
                        o_cpu_hold  <= (RUN_CYCLES == 0);
                        o_busy      <= 1'b1;
                    end
                end
                RUN: begin
                    // Hold rises on the edge the counter hits zero, so the CPU sees exactly RUN_CYCLES cycles.
                    if (runCnt != '0) begin
                        runCnt <= runCnt - RUN_ONE;
                        if (runCnt == RUN_ONE) o_cpu_hold <= 1'b1;
                    end
                end
                ISSUE: begin
                    o_addr  <= entryAddr[idx];
                    waitCnt <= WAIT_INIT;
                end
                WAIT: begin
                    if (waitCnt != WAIT_ONE) waitCnt <= waitCnt - WAIT_ONE;
                end
                COMPARE: begin
                    if (mismatch) begin
                        if (o_err_count != ERR_MAX) o_err_count <= o_err_count + ERR_ONE;
                        if (o_err_count == '0) begin
                            o_fail_idx  <= idx;
                            o_fail_data <= i_ram_data;
                        end
                    end
                    if (stateNext == DONE) begin
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        o_pass <= (o_err_count == '0) && !mismatch;
                    end else begin
                        idx <= idx + IDX_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fbcpu_mem_checker.sv
// Self-checking bench for fbcpu_mem_checker: table vectors, timing corner cases and randomized runs vs a reference model.
module tb_fbcpu_mem_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        startV   [2];
    logic [23:0] eAddrV   [2];
    logic [39:0] eDataV   [2];
    logic        holdV    [2];
    logic [5:0]  addrV    [2];
    logic        busyV    [2];
    logic        doneV    [2];
    logic        passV    [2];
    logic [1:0]  fIdxV    [2];
    logic [9:0]  fDataV   [2];
    logic [2:0]  errV     [2];
    logic [9:0]  mem      [64];

    // Instance 0: RUN_CYCLES=12, READ_LATENCY=1. Instance 1: RUN_CYCLES=0, READ_LATENCY=2.
    for (genvar g = 0; g < 2; g++) begin : gInst
        logic [9:0] q0, q1;
        always @(posedge clk) begin
            q0 <= mem[addrV[g]];
            q1 <= q0;
        end
        fbcpu_mem_checker #(
            .ADDRESS_WIDTH(6), .DATA_WIDTH(10), .NUM_CHECKS(4),
            .RUN_CYCLES(g == 0 ? 12 : 0), .READ_LATENCY(g == 0 ? 1 : 2)
        ) dut (
            .clk(clk), .rst(rst), .i_start(startV[g]),
            .i_exp_addr(eAddrV[g]), .i_exp_data(eDataV[g]),
            .i_ram_data(g == 0 ? q0 : q1),
            .o_cpu_hold(holdV[g]), .o_addr(addrV[g]), .o_busy(busyV[g]),
            .o_done(doneV[g]), .o_pass(passV[g]), .o_fail_idx(fIdxV[g]),
            .o_fail_data(fDataV[g]), .o_err_count(errV[g])
        );
    end

    // Instance B: single check, full 10000-cycle run, with a stub CPU that stores 15 at 52 while running.
    logic       startB, clrB, holdB, busyB, doneB, passB, fIdxB;
    logic [5:0] eAddrB, addrB;
    logic [9:0] eDataB, fDataB, memB52, qB;
    logic [1:0] errB;

    always @(posedge clk) begin
        if (clrB) memB52 <= 10'd0;
        else if (!holdB) memB52 <= 10'd15;
        qB <= (addrB == 6'd52) ? memB52 : 10'h0AA;
    end

    fbcpu_mem_checker #(
        .ADDRESS_WIDTH(6), .DATA_WIDTH(10), .NUM_CHECKS(1),
        .RUN_CYCLES(10000), .READ_LATENCY(1)
    ) dutB (
        .clk(clk), .rst(rst), .i_start(startB),
        .i_exp_addr(eAddrB), .i_exp_data(eDataB), .i_ram_data(qB),
        .o_cpu_hold(holdB), .o_addr(addrB), .o_busy(busyB), .o_done(doneB),
        .o_pass(passB), .o_fail_idx(fIdxB), .o_fail_data(fDataB), .o_err_count(errB)
    );

    int nChecks = 0;
    int nFail   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [23:0] pa(input int a0, input int a1, input int a2, input int a3);
        return {a3[5:0], a2[5:0], a1[5:0], a0[5:0]};
    endfunction

    function automatic logic [39:0] pd(input int d0, input int d1, input int d2, input int d3);
        return {d3[9:0], d2[9:0], d1[9:0], d0[9:0]};
    endfunction

    // Reference: walk the table against the RAM image, counting mismatches and noting the first.
    function automatic void model(input logic [23:0] a, input logic [39:0] d,
                                  output int errs, output int fidx, output int fdata, output int nchk);
        logic [9:0] v;
        errs = 0; fidx = 0; fdata = 0; nchk = 4;
        for (int k = 0; k < 4; k++) begin
            v = mem[a[k*6 +: 6]];
            if (v != d[k*10 +: 10]) begin
                if (errs == 0) begin
                    fidx  = k;
                    fdata = v;
                end
                errs++;
`ifdef FBCHK_STOP_ON_FAIL_EN
                nchk = k + 1;
                break;
`endif
            end
        end
    endfunction

    int         rLat, rAddrErr, rBusyErr, rHoldLow;
    logic       rPass, rHold;
    logic [2:0] rErr;
    logic [1:0] rFIdx;
    logic [9:0] rFData;

    task automatic runG(input int g, input logic [23:0] a, input logic [39:0] d,
                        input int nchk, input int midStart);
        int runC, p, e, n, l, k;
        runC = (g == 0) ? 12 : 0;
        p    = (g == 0) ? 3 : 4;
        e    = runC + 1 + nchk * p;
        eAddrV[g] = a;
        eDataV[g] = d;
        rLat = -1; rAddrErr = 0; rBusyErr = 0; rHoldLow = 0;
        @(negedge clk);
        startV[g] = 1'b1;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            l = n - 1;
            if (!holdV[g]) rHoldLow++;
            if (l >= runC + 2) begin
                k = (l - runC - 2) / p;
                if (k >= nchk) k = nchk - 1;
                if (addrV[g] !== a[k*6 +: 6]) rAddrErr++;
            end
            if (busyV[g] !== (l < e)) rBusyErr++;
            if (doneV[g]) begin
                rLat = l;
                break;
            end
            startV[g] = (n == midStart);
        end
        startV[g] = 1'b0;
        rPass = passV[g]; rErr = errV[g]; rFIdx = fIdxV[g]; rFData = fDataV[g]; rHold = holdV[g];
    endtask

    task automatic verify(input string tag, input int g, input int nchk,
                          input int errs, input int fidx, input int fdata);
        int runC, p;
        runC = (g == 0) ? 12 : 0;
        p    = (g == 0) ? 3 : 4;
        check({tag, " latency"}, rLat, runC + 1 + nchk * p);
        check({tag, " pass"}, rPass, (errs == 0));
        check({tag, " err_count"}, rErr, errs);
        check({tag, " fail_idx"}, rFIdx, fidx);
        check({tag, " fail_data"}, rFData, fdata);
        check({tag, " addr timing"}, rAddrErr, 0);
        check({tag, " busy timing"}, rBusyErr, 0);
        check({tag, " cpu run cycles"}, rHoldLow, runC);
        check({tag, " hold at done"}, rHold, 1);
    endtask

    typedef struct {
        logic [23:0] a;
        logic [39:0] d;
        int          errs;
        int          fidx;
        int          fdata;
    } vecT;

    vecT tbl [5];

    initial begin
        int exErr, exN, errs, fidx, fdata, nchk, midStart, n;
        logic [23:0] ra;
        logic [39:0] rd;
        logic [9:0]  v;

        rst = 1'b1; clrB = 1'b1; startB = 1'b0; eAddrB = '0; eDataB = '0;
        for (int g = 0; g < 2; g++) begin
            startV[g] = 1'b0; eAddrV[g] = '0; eDataV[g] = '0;
        end
        for (int i = 0; i < 64; i++) mem[i] = 10'(i * 7);
        mem[0] = 10'h3FF; mem[1] = 10'd1; mem[2] = 10'd2; mem[3] = 10'd3;
        repeat (3) @(negedge clk);
        rst = 1'b0; clrB = 1'b0;
        @(negedge clk);

        for (int g = 0; g < 2; g++) begin
            check("reset hold", holdV[g], 1);
            check("reset busy", busyV[g], 0);
            check("reset done", doneV[g], 0);
            check("reset addr", addrV[g], 0);
            check("reset err_count", errV[g], 0);
        end
        check("reset hold B", holdB, 1);

        tbl[0] = '{pa(0, 1, 2, 3), pd(10'h3FF, 9, 2, 7),        2, 1, 1};
        tbl[1] = '{pa(0, 1, 2, 3), pd(10'h3FF, 1, 2, 3),        0, 0, 0};
        tbl[2] = '{pa(3, 3, 3, 3), pd(0, 0, 0, 0),              4, 0, 3};
        tbl[3] = '{pa(2, 0, 2, 1), pd(2, 10'h3FF, 5, 1),        1, 2, 2};
        tbl[4] = '{pa(1, 1, 0, 2), pd(1, 0, 0, 2),              2, 1, 1};

        for (int g = 0; g < 2; g++) begin
            for (int t = 0; t < 5; t++) begin
                exErr = tbl[t].errs;
                exN   = 4;
`ifdef FBCHK_STOP_ON_FAIL_EN
                if (exErr > 0) begin
                    exErr = 1;
                    exN   = tbl[t].fidx + 1;
                end
`endif
                runG(g, tbl[t].a, tbl[t].d, exN, 0);
                verify($sformatf("table g%0d row%0d", g, t), g, exN, exErr, tbl[t].fidx, tbl[t].fdata);
            end
        end

        // Reset while the outputs hold a failed result.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst in done: done", doneV[0], 0);
        check("rst in done: fail_idx", fIdxV[0], 0);
        check("rst in done: fail_data", fDataV[0], 0);
        check("rst in done: err_count", errV[0], 0);
        check("rst in done: addr", addrV[0], 0);

        // Reset mid-WAIT: start, let the first read issue, then pulse rst.
        eAddrV[0] = pa(5, 1, 2, 3);
        eDataV[0] = pd(35, 1, 2, 3);
        @(negedge clk);
        startV[0] = 1'b1;
        @(negedge clk);
        startV[0] = 1'b0;
        repeat (14) @(negedge clk);
        check("pre-rst busy", busyV[0], 1);
        check("pre-rst addr", addrV[0], 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst in wait: hold", holdV[0], 1);
        check("rst in wait: addr", addrV[0], 0);
        check("rst in wait: busy", busyV[0], 0);
        check("rst in wait: done", doneV[0], 0);
        check("rst in wait: pass", passV[0], 0);
        check("rst in wait: err_count", errV[0], 0);
        @(negedge clk);
        check("idle after rst: hold", holdV[0], 1);

        runG(0, pa(5, 1, 2, 3), pd(35, 1, 2, 3), 4, 0);
        verify("after rst", 0, 4, 0, 0, 0);

        // A start pulse while busy must not restart the sequence.
        runG(0, tbl[1].a, tbl[1].d, 4, 6);
        verify("start in run", 0, 4, 0, 0, 0);
        runG(1, tbl[1].a, tbl[1].d, 4, 9);
        verify("start in check", 1, 4, 0, 0, 0);

        // Single-entry, full-length run with a CPU that writes 15 to address 52.
        for (int pass = 0; pass < 2; pass++) begin
            clrB = 1'b1;
            @(negedge clk);
            clrB = 1'b0;
            eAddrB = 6'd52;
            eDataB = (pass == 0) ? 10'd15 : 10'd50;
            startB = 1'b1;
            rLat = -1; rHoldLow = 0; n = 0;
            while (n < 10200) begin
                @(negedge clk);
                n++;
                startB = 1'b0;
                if (!holdB) rHoldLow++;
                if (doneB) begin
                    rLat = n - 1;
                    break;
                end
            end
            check($sformatf("B%0d latency", pass), rLat, 10004);
            check($sformatf("B%0d cpu run cycles", pass), rHoldLow, 10000);
            check($sformatf("B%0d pass", pass), passB, (pass == 0));
            check($sformatf("B%0d err_count", pass), errB, pass);
            check($sformatf("B%0d fail_idx", pass), fIdxB, 0);
            check($sformatf("B%0d fail_data", pass), fDataB, (pass == 0) ? 0 : 15);
        end

        // Randomized tables over a small address range so duplicates are common.
        for (int g = 0; g < 2; g++) begin
            for (int it = 0; it < 10; it++) begin
                for (int i = 0; i < 8; i++) mem[i] = 10'($urandom_range(0, 1023));
                for (int k = 0; k < 4; k++) begin
                    ra[k*6 +: 6] = 6'($urandom_range(0, 7));
                    v = mem[ra[k*6 +: 6]];
                    rd[k*10 +: 10] = ($urandom_range(0, 1) == 0) ? v : 10'($urandom_range(0, 1023));
                end
                midStart = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 12)) : 0;
                model(ra, rd, errs, fidx, fdata, nchk);
                runG(g, ra, rd, nchk, midStart);
                verify($sformatf("rand g%0d it%0d", g, it), g, nchk, errs, fidx, fdata);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
